// File: rtl/ccff_chain_mem.sv
// Configuration chain memory: serial shift register feeding a commit-validated shadow register.
// Define CCFF_CHAIN_PARITY_EN to enable the even-parity check on commit.
module ccff_chain_mem #(
  parameter int                  NUM_BITS  = 16,
  parameter logic [NUM_BITS-1:0] RESET_VAL = '0,
  localparam int                 CNT_W     = $clog2(NUM_BITS + 1)
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                ccff_head,
  input  logic                shift_en,
  input  logic                commit,
  input  logic                ccff_parity,
  output logic                ccff_tail,
  output logic [NUM_BITS-1:0] mem_out,
  output logic [CNT_W-1:0]    shift_cnt,
  output logic                chain_full,
  output logic                overflow,
  output logic                commit_done,
  output logic                parity_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BITS);

  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] mem_q, mem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                overflow_q, overflow_d;
  logic                commit_done_q, commit_done_d;
  logic                parity_err_d;
  logic                parity_ok;
  logic                full;

  assign full = (cnt_q == FULL_CNT);

`ifdef CCFF_CHAIN_PARITY_EN
  logic parity_err_q;

  assign parity_ok  = ((^shift_q) == ccff_parity);
  assign parity_err = parity_err_q;
`else
  logic unused_parity;

  assign parity_ok     = 1'b1;
  assign unused_parity = ccff_parity ^ parity_err_d;
  assign parity_err    = 1'b0;
`endif

  // Shifting has priority; a commit only acts on a cycle with no shift.
  always_comb begin
    shift_d       = shift_q;
    mem_d         = mem_q;
    cnt_d         = cnt_q;
    overflow_d    = overflow_q;
    commit_done_d = 1'b0;
    parity_err_d  = 1'b0;
    if (shift_en) begin
      shift_d[0] = ccff_head;
      for (int i = 1; i < NUM_BITS; i++) begin
        shift_d[i] = shift_q[i-1];
      end
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (commit) begin
      cnt_d      = '0;
      overflow_d = 1'b0;
      if (full && !overflow_q) begin
        if (parity_ok) begin
          mem_d         = shift_q;
          commit_done_d = 1'b1;
        end else begin
          parity_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shift_q       <= RESET_VAL;
      mem_q         <= RESET_VAL;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      mem_q         <= mem_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      commit_done_q <= commit_done_d;
    end
  end

`ifdef CCFF_CHAIN_PARITY_EN
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
`endif

  assign ccff_tail   = shift_q[NUM_BITS-1];
  assign mem_out     = mem_q;
  assign shift_cnt   = cnt_q;
  assign chain_full  = full;
  assign overflow    = overflow_q;
  assign commit_done = commit_done_q;

endmodule

// File: tb/tb_ccff_chain_mem.sv
// Scoreboard bench for ccff_chain_mem (NUM_BITS=4): directed vectors push expected
// post-edge outputs, a monitor pops and compares them one cycle at a time.
module tb_ccff_chain_mem;

  logic       prog_clk;
  logic       prog_reset;
  logic       ccff_head;
  logic       shift_en;
  logic       commit;
  logic       ccff_parity;
  logic       ccff_tail;
  logic [3:0] mem_out;
  logic [2:0] shift_cnt;
  logic       chain_full;
  logic       overflow;
  logic       commit_done;
  logic       parity_err;

  // expected word layout: {mem[3:0], cnt[2:0], tail, full, ovf, done, perr}
  typedef struct {
    int          idx;
    logic [11:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       total = 0;
  int       bad   = 0;
  int       vec_n = 0;

  ccff_chain_mem #(
    .NUM_BITS (4),
    .RESET_VAL(4'b0000)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff_head  (ccff_head),
    .shift_en   (shift_en),
    .commit     (commit),
    .ccff_parity(ccff_parity),
    .ccff_tail  (ccff_tail),
    .mem_out    (mem_out),
    .shift_cnt  (shift_cnt),
    .chain_full (chain_full),
    .overflow   (overflow),
    .commit_done(commit_done),
    .parity_err (parity_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Drive one cycle of inputs, then queue what the outputs must be after that edge.
  task automatic applyStimulus(input logic rst, input logic head, input logic sh,
                               input logic cm, input logic par, input logic [11:0] exp);
    sb_item_t it;
    prog_reset  = rst;
    ccff_head   = head;
    shift_en    = sh;
    commit      = cm;
    ccff_parity = par;
    @(posedge prog_clk);
    #1;
    it.idx = vec_n;
    it.exp = exp;
    sb_q.push_back(it);
    vec_n++;
  endtask

  task automatic checkOutput(input sb_item_t it);
    logic [11:0] got;
    got = {mem_out, shift_cnt, ccff_tail, chain_full, overflow, commit_done, parity_err};
    total++;
    if (got !== it.exp) begin
      bad++;
      $display("[TB] FAIL vec%0d {mem,cnt,tail,full,ovf,done,perr}: got=%b_%b_%b%b%b%b%b need=%b_%b_%b",
               it.idx, got[11:8], got[7:5], got[4], got[3], got[2], got[1], got[0],
               it.exp[11:8], it.exp[7:5], it.exp[4:0]);
    end
  endtask

  always @(negedge prog_clk) begin
    if (sb_q.size() > 0) begin
      checkOutput(sb_q.pop_front());
    end
  end

`ifdef CCFF_CHAIN_PARITY_EN
  localparam logic [3:0] MEM_AFTER_P0 = 4'b0000;
  localparam logic       DONE_P0      = 1'b0;
  localparam logic       PERR_P0      = 1'b1;
`else
  localparam logic [3:0] MEM_AFTER_P0 = 4'b1101;
  localparam logic       DONE_P0      = 1'b1;
  localparam logic       PERR_P0      = 1'b0;
`endif

  initial begin
    int wait_cycles;
    prog_reset  = 1'b1;
    ccff_head   = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    ccff_parity = 1'b0;

    //            rst head sh cm par   mem     cnt  tail full ovf done perr
    applyStimulus(1, 0, 0, 0, 0, {4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 0, 0, 0, {4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // load 1101
    applyStimulus(0, 1, 1, 0, 0, {4'b0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 1, 1, 0, 0, {4'b0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 1, 0, 0, {4'b0000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 1, 1, 0, 0, {4'b0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 0, 1, 1, {4'b1101, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    applyStimulus(0, 0, 0, 0, 0, {4'b1101, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    // five shifts: 1010, 0100, 1000, 0000, 0001 with overflow on the fifth
    applyStimulus(0, 0, 1, 0, 0, {4'b1101, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 1, 0, 0, {4'b1101, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 1, 0, 0, {4'b1101, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 1, 0, 0, {4'b1101, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 1, 1, 0, 0, {4'b1101, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    applyStimulus(0, 0, 0, 1, 1, {4'b1101, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 0, 0, 0, {4'b1101, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // partial load of two bits (0011, 0111), commit rejected, then back-to-back commit
    applyStimulus(0, 1, 1, 0, 0, {4'b1101, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 1, 1, 0, 0, {4'b1101, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 0, 1, 1, {4'b1101, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 0, 1, 1, {4'b1101, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // commit with shift_en: shift wins (1110), no pulse
    applyStimulus(0, 0, 1, 1, 1, {4'b1101, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 1, 1, 0, 0, {4'b1101, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    // reset mid-load overrides a concurrent shift
    applyStimulus(1, 1, 1, 0, 0, {4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // reload 1101 and commit with the wrong parity bit
    applyStimulus(0, 1, 1, 0, 0, {4'b0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 1, 1, 0, 0, {4'b0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 1, 0, 0, {4'b0000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 1, 1, 0, 0, {4'b0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    applyStimulus(0, 0, 0, 1, 0, {MEM_AFTER_P0, 3'd0, 1'b1, 1'b0, 1'b0, DONE_P0, PERR_P0});
    applyStimulus(0, 0, 0, 0, 0, {MEM_AFTER_P0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(posedge prog_clk);
      wait_cycles++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got=%0d pending need=0", sb_q.size());
    end
    if (total != vec_n) begin
      total++;
      bad++;
      $display("[TB] FAIL checkcount: got=%0d need=%0d", total - 1, vec_n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
